// File: rtl/npu_pkg.sv
// Shared parameters, FSM state type and result formatting for the NPU matmul responder.
// sat_acc is selected by the top when NPU_MM_SAT_EN is defined; wrap_acc otherwise.
package npu_pkg;
  localparam int N      = 4;
  localparam int AW     = 8;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX32 = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN32 = 64'shFFFF_FFFF_8000_0000;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, STORE, ACK, WAIT_LOW} state_t;

  function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
    if (v > ACC_MAX32)
      return 32'sh7FFF_FFFF;
    else if (v < ACC_MIN32)
      return 32'sh8000_0000;
    else
      return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] wrap_acc(input logic signed [ACC_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/npu_mac.sv
// Single multiply-accumulate unit: signed 32x32 product into a 64-bit accumulator.
// clr restarts the sum with the current product so no separate clear cycle is needed.
module npu_mac
  import npu_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [ACC_W-1:0] a_x, b_x, prod_p0, acc_p1;

  assign a_x     = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_x     = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_p0 = a_x * b_x;

  // p0 -> p1: accumulate
  always_ff @(posedge clk) begin
    if (en)
      acc_p1 <= (clr ? '0 : acc_p1) + prod_p0;
  end

  assign acc = acc_p1;
endmodule

// File: rtl/npu_mm_responder.sv
// NPU matmul responder: loads A and B from shared memory, computes C = A x B, stores C, pulses ack.
// Define NPU_MM_SAT_EN to clamp each result to the signed 32-bit range instead of wrapping.
module npu_mm_responder
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [AW-1:0]     src1_addr,
  input  logic [AW-1:0]     src2_addr,
  input  logic [AW-1:0]     rd_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              ack
);
  localparam int CW = $clog2(2 * N * N + 1);
  localparam int BW = $clog2(2 * N * N);
  localparam int IW = $clog2(N);

  localparam logic [CW-1:0] NN_C     = CW'(N * N);
  localparam logic [CW-1:0] TOT_C    = CW'(2 * N * N);
  localparam logic [CW-1:0] LAST_CAP = CW'(2 * N * N - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [BW-1:0] N_B      = BW'(N);
  localparam logic [BW-1:0] NN_B     = BW'(N * N);

  state_t                    state;
  logic [AW-1:0]             src1_q, src2_q, dst_q;
  logic [CW-1:0]             rd_cnt, cap_cnt;
  logic                      cap_vld_p1;
  logic [IW-1:0]             i_q, j_q, k_q;
  logic signed [DATA_W-1:0]  ab_buf [2*N*N];
  logic [BW-1:0]             a_idx, b_idx, out_idx;
  logic [AW-1:0]             rd_next_addr, st_addr;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  res;

  // Operand selection: A is buffer words 0..N*N-1, B follows it.
  assign a_idx   = BW'(i_q) * N_B + BW'(k_q);
  assign b_idx   = NN_B + BW'(k_q) * N_B + BW'(j_q);
  assign out_idx = BW'(i_q) * N_B + BW'(j_q);

  assign rd_next_addr = (rd_cnt < NN_C) ? src1_q + AW'(rd_cnt)
                                        : src2_q + AW'(rd_cnt - NN_C);
  assign st_addr = dst_q + AW'(out_idx);

  npu_mac u_mac (
    .clk (clk),
    .clr (k_q == '0),
    .en  (state == CALC),
    .a   (ab_buf[a_idx]),
    .b   (ab_buf[b_idx]),
    .acc (acc)
  );

`ifdef NPU_MM_SAT_EN
  assign res = sat_acc(acc);
`else
  assign res = wrap_acc(acc);
`endif

  assign mem_wd = mem_wr ? res : '0;

  // Data capture: command addresses and returned matrix words
  always_ff @(posedge clk) begin
    if (state == IDLE && en) begin
      src1_q <= src1_addr;
      src2_q <= src2_addr;
      dst_q  <= rd_addr;
    end
    if (state == LOAD && cap_vld_p1)
      ab_buf[BW'(cap_cnt)] <= mem_rdata;
  end

  // Control FSM with registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      rd_cnt     <= '0;
      cap_cnt    <= '0;
      cap_vld_p1 <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      cap_vld_p1 <= mem_rd;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= LOAD;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= src1_addr;
            rd_cnt   <= CW'(1);
            cap_cnt  <= '0;
          end
        end
        LOAD: begin
          if (rd_cnt < TOT_C) begin
            mem_rd   <= 1'b1;
            mem_addr <= rd_next_addr;
            rd_cnt   <= rd_cnt + CW'(1);
          end else begin
            mem_rd <= 1'b0;
          end
          if (cap_vld_p1) begin
            cap_cnt <= cap_cnt + CW'(1);
            if (cap_cnt == LAST_CAP) begin
              state <= CALC;
              i_q   <= '0;
              j_q   <= '0;
              k_q   <= '0;
            end
          end
        end
        CALC: begin
          if (k_q == LAST_IDX) begin
            state    <= STORE;
            mem_wr   <= 1'b1;
            mem_addr <= st_addr;
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        STORE: begin
          mem_wr <= 1'b0;
          k_q    <= '0;
          state  <= CALC;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            if (i_q == LAST_IDX) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        ACK: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_mm_responder.sv
// Directed testbench for npu_mm_responder with a 256-word behavioural shared memory.
// Expected values are hand-derived for N=4, AW=8.
module tb_npu_mm_responder;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  src1_addr, src2_addr, rd_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd, mem_rdata;
  logic        busy, ack;

  logic [31:0] mem [256];
  logic [31:0] mat [16];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [7:0]  rd_log [$];
  int          rd_count = 0;
  int          both_count = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  npu_mm_responder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .src1_addr (src1_addr),
    .src2_addr (src2_addr),
    .rd_addr   (rd_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .ack       (ack)
  );

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (mem_wr) mem[mem_addr] <= mem_wd;
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count  <= rd_count + 1;
      rd_log.push_back(mem_addr);
    end
    if (mem_rd && mem_wr) both_count <= both_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] base);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = base + 8'(k);
      pl_data = mat[k];
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] d,
                     output int lat);
    @(negedge clk);
    src1_addr = s1;
    src2_addr = s2;
    rd_addr   = d;
    en        = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (ack !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drop();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, rb, lb;
    logic [7:0] a8;
    logic [31:0] exp_ovf;
    rst = 1'b0; en = 1'b0; src1_addr = '0; src2_addr = '0; rd_addr = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) mat[k] = (k % 5 == 0) ? 32'd1 : 32'd0;
    put(8'h10);
    for (int k = 0; k < 16; k++) mat[k] = 32'(k);
    put(8'h30);
    for (int k = 0; k < 16; k++) mat[k] = 32'd2;
    put(8'h60);
    for (int k = 0; k < 16; k++) mat[k] = 32'd3;
    put(8'h70);
    for (int k = 0; k < 16; k++) mat[k] = 32'd0;
    mat[0] = 32'h7FFF_FFFF;
    put(8'h90);
    mat[0] = 32'd2;
    put(8'hA0);
    for (int k = 0; k < 16; k++) mat[k] = 32'd100 + 32'(k);
    put(8'hF8);
    for (int k = 0; k < 16; k++) mat[k] = 32'hDEAD_BEEF;
    put(8'hC0);

    // Identity x ramp
    rb = rd_count; lb = rd_log.size();
    cmd(8'h10, 8'h30, 8'h50, lat);
    chk("id_ack_cycle", 32'(lat), 32'd114);
    chk("id_busy_at_ack", {31'b0, busy}, 32'd1);
    chk("id_read_count", 32'(rd_count - rb), 32'd32);
    chk("id_first_a_addr", {24'b0, rd_log[lb]}, 32'h10);
    chk("id_first_b_addr", {24'b0, rd_log[lb+16]}, 32'h30);
    @(posedge clk); #1;
    chk("id_ack_one_cycle", {31'b0, ack}, 32'd0);
    chk("id_busy_fall", {31'b0, busy}, 32'd0);
    for (int k = 0; k < 16; k++) chk("id_C", mem[8'h50 + k], 32'(k));
    drop();

    // Uniform, then hold en past ack
    rb = rd_count;
    cmd(8'h60, 8'h70, 8'h80, lat);
    chk("uni_ack_cycle", 32'(lat), 32'd114);
    for (int k = 0; k < 16; k++) chk("uni_C", mem[8'h80 + k], 32'd24);
    rb = rd_count;
    repeat (20) @(posedge clk);
    #1;
    chk("held_no_reads", 32'(rd_count - rb), 32'd0);
    chk("held_busy", {31'b0, busy}, 32'd0);
    chk("held_ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rb = rd_count;
    cmd(8'h60, 8'h70, 8'hE0, lat);
    chk("rearm_ack_cycle", 32'(lat), 32'd114);
    chk("rearm_read_count", 32'(rd_count - rb), 32'd32);
    chk("rearm_C_first", mem[8'hE0], 32'd24);
    chk("rearm_C_last", mem[8'hEF], 32'd24);
    drop();

    // Overflow
`ifdef NPU_MM_SAT_EN
    exp_ovf = 32'h7FFF_FFFF;
`else
    exp_ovf = 32'hFFFF_FFFE;
`endif
    cmd(8'h90, 8'hA0, 8'hB0, lat);
    chk("ovf_C00", mem[8'hB0], exp_ovf);
    chk("ovf_C01", mem[8'hB1], 32'd0);
    chk("ovf_C33", mem[8'hBF], 32'd0);
    drop();

    // Address wrap on A, identity as B
    lb = rd_log.size();
    cmd(8'hF8, 8'h10, 8'h40, lat);
    chk("wrap_addr_7", {24'b0, rd_log[lb+7]}, 32'hFF);
    chk("wrap_addr_8", {24'b0, rd_log[lb+8]}, 32'h00);
    chk("wrap_addr_15", {24'b0, rd_log[lb+15]}, 32'h07);
    for (int k = 0; k < 16; k++) chk("wrap_C", mem[8'h40 + k], 32'd100 + 32'(k));
    drop();

    // Reset in the middle of CALC
    @(negedge clk);
    src1_addr = 8'h60; src2_addr = 8'h70; rd_addr = 8'hC0; en = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_ack", {31'b0, ack}, 32'd0);
    chk("rst_mid_wd", mem_wd, 32'd0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_kept_C4", mem[8'hC4], 32'd24);
    chk("rst_unwritten_C5", mem[8'hC5], 32'hDEAD_BEEF);
    rb = rd_count;
    cmd(8'h60, 8'h70, 8'hD0, lat);
    chk("post_rst_ack_cycle", 32'(lat), 32'd114);
    chk("post_rst_reads", 32'(rd_count - rb), 32'd32);
    for (int k = 0; k < 16; k++) begin
      a8 = 8'hD0 + 8'(k);
      chk("post_rst_C", mem[a8], 32'd24);
    end
    drop();

    chk("strobe_exclusive", 32'(both_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
